// File: rtl/pong_state_fetch_if.sv
// BRAM port B bus between the frame-state fetcher (master) and the memory (slave).
interface pong_state_fetch_if;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic [15:0] q_b;

  modport master (output addr_b, output data_b, output we_b, input q_b);
  modport slave  (input addr_b, input data_b, input we_b, output q_b);
endinterface

// File: rtl/pong_state_fetch.sv
// Once per vblank: write the synced button word to BRAM, burst-read six game-state
// words, and publish them as a clamped, atomically updated snapshot for the renderer.
module pong_state_fetch #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter int          SCREEN_W  = 640,
  parameter int          SCREEN_H  = 480
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vblank_start,
  input  logic [3:0]          buttons,
  pong_state_fetch_if.master  bram,
  output logic [15:0]         ball_x,
  output logic [15:0]         ball_y,
  output logic [15:0]         paddle_l_y,
  output logic [15:0]         paddle_r_y,
  output logic [15:0]         score_l,
  output logic [15:0]         score_r,
  output logic                frame_valid,
  output logic                busy,
  output logic                missed_frame
);

  localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_UPDATE} state_t;

  function automatic logic [15:0] clamp_max(input logic [15:0] v, input logic [15:0] lim_m1);
    return (v > lim_m1) ? lim_m1 : v;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  btn_s1_q, btn_s2_q;
  logic        cap_vld_q;
  logic [2:0]  cap_idx_q;
  logic        issue;
  logic [15:0] shadow_q [6];
  logic [15:0] ball_x_q, ball_y_q, paddle_l_y_q, paddle_r_y_q, score_l_q, score_r_q;
  logic        frame_valid_q, missed_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Bus outputs are decoded from state so an asynchronous reset drops we_b at once.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bram.addr_b = 16'd0;
    bram.data_b = 16'd0;
    bram.we_b   = 1'b0;
    issue       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vblank_start) state_d = S_WRITE;
      end
      S_WRITE: begin
        bram.addr_b = BASE_ADDR + 16'd6;
        bram.data_b = {12'd0, btn_s2_q};
        bram.we_b   = 1'b1;
        idx_d       = 3'd0;
        state_d     = S_READ;
      end
      S_READ: begin
        bram.addr_b = BASE_ADDR + {13'd0, idx_q};
        issue       = 1'b1;
        if (idx_q == 3'd5) state_d = S_DRAIN;
        else               idx_d   = idx_q + 3'd1;
      end
      S_DRAIN:  state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 4'd0;
      btn_s2_q <= 4'd0;
    end else begin
      btn_s1_q <= buttons;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Read data lags its address by one cycle, so capture follows a delayed copy of idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= 3'd0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 16'd0;
    end else begin
      cap_vld_q <= issue;
      cap_idx_q <= idx_q;
      if (cap_vld_q) shadow_q[cap_idx_q] <= bram.q_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ball_x_q      <= 16'd0;
      ball_y_q      <= 16'd0;
      paddle_l_y_q  <= 16'd0;
      paddle_r_y_q  <= 16'd0;
      score_l_q     <= 16'd0;
      score_r_q     <= 16'd0;
      frame_valid_q <= 1'b0;
      missed_q      <= 1'b0;
    end else begin
      frame_valid_q <= (state_q == S_UPDATE);
      if (state_q == S_UPDATE) begin
        ball_x_q     <= clamp_max(shadow_q[0], X_MAX);
        ball_y_q     <= clamp_max(shadow_q[1], Y_MAX);
        paddle_l_y_q <= clamp_max(shadow_q[2], Y_MAX);
        paddle_r_y_q <= clamp_max(shadow_q[3], Y_MAX);
        score_l_q    <= shadow_q[4];
        score_r_q    <= shadow_q[5];
      end
      if (vblank_start && (state_q != S_IDLE)) missed_q <= 1'b1;
    end
  end

  assign ball_x       = ball_x_q;
  assign ball_y       = ball_y_q;
  assign paddle_l_y   = paddle_l_y_q;
  assign paddle_r_y   = paddle_r_y_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign frame_valid  = frame_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign missed_frame = missed_q;

endmodule

// File: doc/pong_state_fetch.md
Name: pong_state_fetch

Overview:
- Peripheral on BRAM port B; the CPU core keeps port A for fetch and data.
- Once per video frame, on a vblank pulse, writes the synchronized player button word into BRAM.
- Then burst-reads six game-state words produced by the CPU program: ball X/Y, left/right paddle Y, left/right score.
- Presents them as stable, clamped registers to the renderer, updated atomically once per frame.

Parameters:
- BASE_ADDR, 16'h0100, first address of the 7-word game-state window in BRAM.
- SCREEN_W, 640, horizontal pixel count; X coordinates clamp to SCREEN_W-1.
- SCREEN_H, 480, vertical pixel count; Y coordinates clamp to SCREEN_H-1.

Ports:
- clk  input  1  system clock, shared with CPU and BRAM.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- vblank_start  input  1  one-cycle pulse at start of vertical blanking, clk domain.
- buttons  input  4  raw asynchronous buttons {R_down,R_up,L_down,L_up}.
- q_b  input  16  BRAM port B read data, registered, 1-cycle latency.
- addr_b  output  16  BRAM port B address.
- data_b  output  16  BRAM port B write data.
- we_b  output  1  BRAM port B write enable.
- ball_x  output  16  frame snapshot, clamped.
- ball_y  output  16  frame snapshot, clamped.
- paddle_l_y  output  16  frame snapshot, clamped.
- paddle_r_y  output  16  frame snapshot, clamped.
- score_l  output  16  frame snapshot, unclamped.
- score_r  output  16  frame snapshot, unclamped.
- frame_valid  output  1  one-cycle pulse when snapshot outputs update.
- busy  output  1  high while not IDLE.
- missed_frame  output  1  sticky: vblank_start seen while busy.

Behaviour:
- Word map (offset from BASE_ADDR): 0 ball_x, 1 ball_y, 2 paddle_l_y, 3 paddle_r_y, 4 score_l, 5 score_r, 6 input word (written by this block).
- Buttons pass through a 2-flop synchronizer; the input word is {12'b0, synced buttons} sampled in WRITE.
- Reset (asynchronous, active-low) forces immediately:
  - every output to 0, including addr_b, data_b, we_b, frame_valid, busy, missed_frame;
  - state to IDLE;
  - shadow registers and synchronizer flops to 0.
- Reset mid-burst aborts with no partial update, and we_b drops at once.
- FSM states: IDLE, WRITE, READ, DRAIN, UPDATE.
- IDLE: we_b=0; on vblank_start go to WRITE.
- WRITE (1 cycle): addr_b=BASE_ADDR+6, data_b=input word, we_b=1; go to READ with idx=0.
- READ (6 cycles): addr_b=BASE_ADDR+idx, we_b=0; idx increments 0..5. After idx=5 issues, go to DRAIN.
- Capture: data for address idx arrives on q_b one cycle after issue and is written into shadow[idx]. Capture is driven by a 1-cycle-delayed idx/valid pipeline, not by the state.
- DRAIN (1 cycle): captures shadow[5]; go to UPDATE.
- UPDATE (1 cycle): all six outputs load from the shadows in the same edge; frame_valid=1 for this cycle only; go to IDLE.
- Latency: vblank_start sampled at edge N, outputs valid and frame_valid high after edge N+9. busy is high for 9 cycles (WRITE 1 + READ 6 + DRAIN 1 + UPDATE 1).
- Outputs hold their values between updates; the renderer never sees a mixed-frame set.
- Clamp rule: unsigned compare.
  - ball_x and ball_y: shadow > limit-1 → limit-1, where limit is SCREEN_W for X and SCREEN_H for Y.
  - paddle_l_y and paddle_r_y: same rule against SCREEN_H.
  - Scores pass unmodified.
- vblank_start while busy=1 is ignored (no restart, no queue) and sets missed_frame. missed_frame clears only on reset.
- vblank_start in the UPDATE cycle also counts as missed. vblank_start in IDLE starts normally.
- addr_b wraps naturally modulo 2^16 if BASE_ADDR+6 overflows; no error is raised.
- we_b is asserted in exactly one cycle per accepted frame and never during READ.

Test Plan:
- Reset: hold reset=0 mid-READ → all outputs 0 and we_b=0 immediately; release and pulse vblank → a normal 9-cycle burst follows.
- Basic frame: preload BRAM 0x100..0x105 = 100,200,50,300,3,7; buttons=4'b0101 held 3 cycles; pulse vblank → BRAM[0x106]=0x0005; frame_valid pulses exactly 9 cycles later; outputs = 100,200,50,300,3,7.
- Clamp: BRAM[0x100]=700, [0x101]=479, [0x102]=480, [0x103]=0xFFFF → ball_x=639, ball_y=479, paddle_l_y=479, paddle_r_y=479.
- Overrun: second vblank 4 cycles after the first → single frame_valid, missed_frame=1 and stays 1 through later normal frames.
- Atomicity: CPU port A rewrites 0x100 during the burst after it has been read → the snapshot keeps the value read at issue time; outputs change only on the frame_valid cycle.
- Wrap: BASE_ADDR=16'hFFFC → write to 0x0002; reads at FFFC,FFFD,FFFE,FFFF,0000,0001 in that order.
